// File: rtl/conv_acc_pkg.sv
// Shared types and helpers for the conv MAC datapath.
package conv_acc_pkg;

   // Handshake sideband carried down the multiplier pipeline with each product.
   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } beat_t;

   // Signed saturation bound for a w-bit result (w <= 64); the caller keeps the low w bits.
   function automatic logic [63:0] sat_bound(input int w, input logic neg);
      logic [63:0] mag;
      mag = (64'd1 << (w - 1)) - 64'd1;
      return neg ? ~mag : mag;
   endfunction

endpackage

// File: rtl/conv_mul_pipe.sv
// Signedness-aware multiplier followed by a NUM_STAGE register chain with a shared enable.
module conv_mul_pipe
   import conv_acc_pkg::*;
#(
   parameter int A_W       = 16,
   parameter int B_W       = 16,
   parameter bit B_SIGNED  = 1'b0,
   parameter int NUM_STAGE = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  beat_t                         beat_i,
   input  logic signed [A_W-1:0]         a_i,
   input  logic        [B_W-1:0]         b_i,
   output beat_t                         beat_o,
   output logic signed [A_W+B_W:0]       p_o
);

   localparam int P_W = A_W + B_W + 1;

   logic signed [B_W:0]     b_ext;
   logic signed [P_W-1:0]   p_d;
   beat_t [NUM_STAGE-1:0]   beat_q;
   logic signed [P_W-1:0]   p_q [NUM_STAGE];

   // b gets one extra bit so both modes become a signed multiply of exact width P_W.
   assign b_ext = B_SIGNED ? $signed({b_i[B_W-1], b_i}) : $signed({1'b0, b_i});
   assign p_d   = a_i * b_ext;

   // Product/beat shift chain; the whole chain holds when en is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_STAGE; i++) begin
            beat_q[i] <= '0;
            p_q[i]    <= '0;
         end
      end else if (en) begin
         beat_q[0] <= beat_i;
         p_q[0]    <= p_d;
         for (int i = 1; i < NUM_STAGE; i++) begin
            beat_q[i] <= beat_q[i-1];
            p_q[i]    <= p_q[i-1];
         end
      end
   end

   assign beat_o = beat_q[NUM_STAGE-1];
   assign p_o    = p_q[NUM_STAGE-1];

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined multiply-accumulate with group framing, saturation and a valid/ready output register.
module conv_mac_pipe
   import conv_acc_pkg::*;
#(
   parameter int A_W       = 16,
   parameter int B_W       = 16,
   parameter bit B_SIGNED  = 1'b0,
   parameter int NUM_STAGE = 3,
   parameter int ACC_W     = 40,
   parameter int OUT_W     = 32,
   parameter bit ACC_EN    = 1'b1,
   parameter bit SAT       = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [A_W-1:0]   a,
   input  logic        [B_W-1:0]   b,
   input  logic                    first,
   input  logic                    last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_sat
);

   localparam int P_W = A_W + B_W + 1;

   beat_t                   in_beat, m_beat;
   logic signed [P_W-1:0]   m_p;
   logic signed [ACC_W-1:0] p_ext, acc_d, acc_q;
   logic [ACC_W-OUT_W:0]    hi;
   logic                    advance, ovf, emit;
   logic [OUT_W-1:0]        res;
   logic                    out_valid_q, out_sat_q;
   logic signed [OUT_W-1:0] out_data_q;

   // Global stall: nothing moves while a result is waiting on downstream.
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   // Pack the input sideband for the multiplier chain.
   always_comb begin
      in_beat       = '0;
      in_beat.valid = in_valid;
      in_beat.first = first;
      in_beat.last  = last;
   end

   conv_mul_pipe #(
      .A_W(A_W), .B_W(B_W), .B_SIGNED(B_SIGNED), .NUM_STAGE(NUM_STAGE)
   ) u_mul (
      .clk(clk), .reset(reset), .en(advance),
      .beat_i(in_beat), .a_i(a), .b_i(b),
      .beat_o(m_beat), .p_o(m_p)
   );

   // Next accumulator value, overflow detection and the clamped/truncated result.
   always_comb begin
      p_ext = ACC_W'(m_p);
      acc_d = (m_beat.first || !ACC_EN) ? p_ext : acc_q + p_ext;
      // Fits in OUT_W signed iff all bits from OUT_W-1 upward agree.
      hi    = acc_d[ACC_W-1:OUT_W-1];
      ovf   = !((&hi) || !(|hi));
      res   = (SAT && ovf) ? OUT_W'(sat_bound(OUT_W, acc_d[ACC_W-1])) : acc_d[OUT_W-1:0];
      emit  = m_beat.valid && (m_beat.last || !ACC_EN);
   end

   // Accumulator and output register; both freeze during a stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else if (advance) begin
         if (m_beat.valid) acc_q <= acc_d;
         if (emit) begin
            out_valid_q <= 1'b1;
            out_data_q  <= res;
            out_sat_q   <= SAT && ovf;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule
